rca_8bit_core: RTL and testbench

RCA_8BIT_CORE -- requirements
Module: rca_8bit

---
 rtl/rca_8bit_core.sv | 91 +++++++++
 tb/tb_rca_8bit_core.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rca_8bit_core.sv
// 8-bit ripple-carry adder with a one-cycle registered output and valid strobe.
// Optional signed-overflow and zero flags are enabled by defining RCA_8BIT_FLAGS_EN.
module rca_8bit_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic       in_valid,
  output logic [7:0] sum,
  output logic       cout,
  output logic       out_valid
`ifdef RCA_8BIT_FLAGS_EN
  ,
  output logic       ovf,
  output logic       zero
`endif
);

  logic [8:0] c;
  logic [7:0] s;

  logic [7:0] sum_q,   sum_d;
  logic       cout_q,  cout_d;
  logic       valid_q, valid_d;

  // Carry chain evaluated stage by stage inside one block so each c[i+1] sees c[i].
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 8; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = s;
      cout_d = c[8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

`ifdef RCA_8BIT_FLAGS_EN
  logic ovf_q,  ovf_d;
  logic zero_q, zero_d;

  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (in_valid) begin
      ovf_d  = c[7] ^ c[8];
      zero_d = (s == 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_rca_8bit_core.sv
// Scoreboard bench for rca_8bit_core: driver pushes expected results, monitor pops on out_valid.
module tb_rca_8bit_core;

  logic       clk;
  logic       rst_n;
  logic [7:0] a, b;
  logic       cin, in_valid;
  logic [7:0] sum;
  logic       cout, out_valid;
`ifdef RCA_8BIT_FLAGS_EN
  logic       ovf, zero;
`endif

  rca_8bit_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef RCA_8BIT_FLAGS_EN
    ,
    .ovf       (ovf),
    .zero      (zero)
`endif
  );

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    logic       z;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow by range check.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic ci);
    exp_t e;
    int   u, sg;
    u   = int'(x) + int'(y) + int'(ci);
    sg  = int'($signed(x)) + int'($signed(y)) + int'(ci);
    e.s = u[7:0];
    e.c = u[8];
    e.o = (sg > 127) || (sg < -128);
    e.z = (u[7:0] == 8'h00);
    return e;
  endfunction

  task automatic cycle(input logic v, input logic [7:0] x, input logic [7:0] y, input logic ci);
    @(negedge clk);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = ci;
    @(posedge clk);
    if (v && rst_n) q.push_back(model(x, y, ci));
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_sum"},   {1'b0, sum},       9'h000);
    check({name, "_cout"},  {8'h00, cout},     9'h000);
    check({name, "_valid"}, {8'h00, out_valid}, 9'h000);
`ifdef RCA_8BIT_FLAGS_EN
    check({name, "_ovf"},   {8'h00, ovf},      9'h000);
    check({name, "_zero"},  {8'h00, zero},     9'h000);
`endif
  endtask

  // Monitor: out_valid must line up exactly with pending scoreboard entries.
  initial begin
    last = '{s: 8'h00, c: 1'b0, o: 1'b0, z: 1'b0};
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check_zero_outputs("in_reset");
        q.delete();
        last = '{s: 8'h00, c: 1'b0, o: 1'b0, z: 1'b0};
      end else begin
        check("valid_align", {8'h00, out_valid}, {8'h00, (q.size() > 0)});
        if (out_valid && q.size() > 0) last = q.pop_front();
        check("sum",  {1'b0, sum},   {1'b0, last.s});
        check("cout", {8'h00, cout}, {8'h00, last.c});
`ifdef RCA_8BIT_FLAGS_EN
        check("ovf",  {8'h00, ovf},  {8'h00, last.o});
        check("zero", {8'h00, zero}, {8'h00, last.z});
`endif
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    #3;
    check_zero_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors including full ripple and overflow corners
    cycle(1'b1, 8'h05, 8'h03, 1'b0);
    cycle(1'b1, 8'hFF, 8'h01, 1'b0);
    cycle(1'b1, 8'h80, 8'h80, 1'b0);
    cycle(1'b1, 8'h6C, 8'h36, 1'b1);
    cycle(1'b1, 8'hFF, 8'hFF, 1'b1);
    cycle(1'b1, 8'h7F, 8'h00, 1'b1);
    cycle(1'b0, 8'h11, 8'h22, 1'b0);
    cycle(1'b0, 8'h33, 8'h44, 1'b1);
    cycle(1'b1, 8'h00, 8'h00, 1'b0);

    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));

    // Reset mid-cycle with an operation in flight: it must be discarded.
    cycle(1'b1, 8'h05, 8'h03, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'h12;
    b        = 8'h34;
    cin      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);

    cycle(1'b1, 8'hA5, 8'h5A, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 50; i++)
      cycle(($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
    cycle(1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    check("queue_drained", 9'(q.size()), 9'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
